// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage F/D/X/M/W pipeline.
// The block does three things:
//   - holds the front end while a multi-cycle mult/div runs, with a watchdog,
//   - inserts a one-cycle load-use bubble,
//   - squashes wrong-path instructions on taken branches and jumps.
// All control outputs are combinational from the FSM state and the current
// inputs, so they take effect in the same cycle.
// Optional macro HAZARD_PERF_EN adds stall and flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int MD_MAX_CYCLES = 40    // MD_WAIT watchdog limit, must be <= 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] fd_rs1,
    input  logic [4:0] fd_rs2,
    input  logic       fd_uses_rs2,
    input  logic       dx_is_load,
    input  logic [4:0] dx_rd,
    input  logic       branch_taken,
    input  logic       jump_taken,
    input  logic       md_start,
    input  logic       md_ready,
    input  logic       md_exception,
    output logic       stall_pc,
    output logic       stall_fd,
    output logic       stall_dx,
    output logic       bubble_dx,
    output logic       bubble_xm,
    output logic       flush_fd,
    output logic       flush_dx,
    output logic       md_busy,
    output logic       md_error,
    output logic [1:0] state
`ifdef HAZARD_PERF_EN
    ,
    input  logic        perf_clear,
    output logic [31:0] perf_stall_cycles,
    output logic [15:0] perf_flushes
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1
    } state_t;

    // Last md_cnt value before the watchdog fires
    // (the count starts at 0 on the first MD_WAIT cycle).
    localparam logic [5:0] MD_LAST = 6'(MD_MAX_CYCLES - 1);

    state_t     state_q;
    logic [5:0] md_cnt;
    logic       load_use;
    logic       redirect;

    // The multdiv exception is owned by the exception logic downstream;
    // this block only sees it and takes no action on it.
    logic       unused_md_exception;
    assign unused_md_exception = md_exception;

    assign state = state_q;

    // Register 0 is hardwired to zero, so it never creates a RAW hazard.
    assign load_use = dx_is_load && (dx_rd != 5'd0) &&
                      ((dx_rd == fd_rs1) || (fd_uses_rs2 && (dx_rd == fd_rs2)));

    assign redirect = branch_taken || jump_taken;

    // Mealy control outputs from the current state and the current inputs.
    always_comb begin
        stall_pc  = 1'b0;
        stall_fd  = 1'b0;
        stall_dx  = 1'b0;
        bubble_dx = 1'b0;
        bubble_xm = 1'b0;
        flush_fd  = 1'b0;
        flush_dx  = 1'b0;
        md_busy   = 1'b0;
        md_error  = 1'b0;
        case (state_q)
            RUN: begin
                if (redirect) begin
                    flush_fd = 1'b1;
                    flush_dx = 1'b1;
                end else if (md_start) begin
                    // The issue cycle itself runs unstalled.
                end else if (load_use) begin
                    // The bubble pushes the load on to M, so one cycle is enough.
                    stall_pc  = 1'b1;
                    stall_fd  = 1'b1;
                    bubble_dx = 1'b1;
                end
            end
            MD_WAIT: begin
                // X is frozen, so redirects, load-use and md_start are ignored.
                md_busy = 1'b1;
                if (!md_ready) begin
                    stall_pc  = 1'b1;
                    stall_fd  = 1'b1;
                    stall_dx  = 1'b1;
                    bubble_xm = 1'b1;
                    if (md_cnt == MD_LAST) begin
                        md_error = 1'b1;
                    end
                end
            end
            default: begin
                // Illegal encodings: everything stays quiet until recovery.
            end
        endcase
    end

    // State register and mult/div wait counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            md_cnt  <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (!redirect && md_start) begin
                        state_q <= MD_WAIT;
                        md_cnt  <= '0;
                    end
                end
                MD_WAIT: begin
                    if (md_cnt != '1) begin
                        md_cnt <= md_cnt + 6'd1;
                    end
                    // md_ready and the watchdog both leave; md_ready masks md_error.
                    if (md_ready || (md_cnt == MD_LAST)) begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    // Performance counters: cycles with the PC held, and cycles with a flush.
    always_ff @(posedge clock) begin
        if (reset || perf_clear) begin
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
        end else begin
            if (stall_pc) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (flush_fd) begin
                perf_flushes <= perf_flushes + 16'd1;
            end
        end
    end
`endif

endmodule
